// File: rtl/commit_unit.sv
// commit_unit: in-order retirement buffer between dispatch and the rename commit port.
// Records dispatched instructions, collects out-of-order completions, retires one per cycle.
module commit_unit #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int CMPL_W  = 2,
  parameter int TAG_W   = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [FETCH_W-1:0]              disp_valid,
  input  logic [FETCH_W-1:0]              disp_rd_valid,
  input  logic [FETCH_W-1:0][4:0]         disp_arch_rd,
  input  logic [FETCH_W-1:0][5:0]         disp_phys_rd,
  input  logic [FETCH_W-1:0][5:0]         disp_old_phys,
  output logic                            disp_ready,
  output logic [FETCH_W-1:0][TAG_W-1:0]   disp_tag,
  input  logic [CMPL_W-1:0]               cmpl_valid,
  input  logic [CMPL_W-1:0][TAG_W-1:0]    cmpl_tag,
  input  logic                            flush,
  output logic                            commit_en,
  output logic [4:0]                      commit_arch_rd,
  output logic [5:0]                      commit_phys_rd,
  output logic                            free_en,
  output logic [5:0]                      free_phys,
  output logic                            retire_valid,
  output logic [TAG_W:0]                  count
);

  localparam logic [TAG_W:0] READY_MAX = (TAG_W+1)'(DEPTH - FETCH_W);

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [DEPTH-1:0] alloc_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] has_rd_q;
  logic [4:0]       arch_rd_q  [DEPTH];
  logic [5:0]       phys_rd_q  [DEPTH];
  logic [5:0]       old_phys_q [DEPTH];

  logic [TAG_W:0]   n_valid;
  logic [TAG_W:0]   n_disp;
  logic [TAG_W:0]   n_retire;
  logic             disp_fire;
  logic             retire;

  assign disp_ready = (count <= READY_MAX);
  assign disp_fire  = disp_ready && !flush;
  assign retire     = (count != '0) && alloc_q[head_q] && done_q[head_q];
  assign n_disp     = disp_fire ? n_valid : '0;
  assign n_retire   = retire ? (TAG_W+1)'(1) : '0;

  // Valid lanes pack onto consecutive tail slots; idle lanes simply show tail+lane.
  always_comb begin
    n_valid  = '0;
    disp_tag = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (disp_valid[i]) begin
        disp_tag[i] = tail_q + n_valid[TAG_W-1:0];
        n_valid     = n_valid + (TAG_W+1)'(1);
      end else begin
        disp_tag[i] = tail_q + TAG_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count    <= '0;
      alloc_q  <= '0;
      done_q   <= '0;
      has_rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        arch_rd_q[i]  <= '0;
        phys_rd_q[i]  <= '0;
        old_phys_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count   <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      for (int c = 0; c < CMPL_W; c++) begin
        if (cmpl_valid[c] && alloc_q[cmpl_tag[c]]) begin
          done_q[cmpl_tag[c]] <= 1'b1;
        end
      end
      // Retire clear is issued after completions so it wins on the head slot.
      if (retire) begin
        alloc_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + TAG_W'(1);
      end
      if (disp_fire) begin
        for (int i = 0; i < FETCH_W; i++) begin
          if (disp_valid[i]) begin
            alloc_q[disp_tag[i]]    <= 1'b1;
            done_q[disp_tag[i]]     <= 1'b0;
            has_rd_q[disp_tag[i]]   <= disp_rd_valid[i] && (disp_arch_rd[i] != 5'd0);
            arch_rd_q[disp_tag[i]]  <= disp_arch_rd[i];
            phys_rd_q[disp_tag[i]]  <= disp_phys_rd[i];
            old_phys_q[disp_tag[i]] <= disp_old_phys[i];
          end
        end
        tail_q <= tail_q + n_valid[TAG_W-1:0];
      end
      count <= count + n_disp - n_retire;
    end
  end

  // Commit outputs are single-cycle pulses, zero whenever nothing retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_valid   <= 1'b0;
      commit_en      <= 1'b0;
      free_en        <= 1'b0;
      commit_arch_rd <= '0;
      commit_phys_rd <= '0;
      free_phys      <= '0;
    end else if (flush || !retire) begin
      retire_valid   <= 1'b0;
      commit_en      <= 1'b0;
      free_en        <= 1'b0;
      commit_arch_rd <= '0;
      commit_phys_rd <= '0;
      free_phys      <= '0;
    end else begin
      retire_valid   <= 1'b1;
      commit_en      <= has_rd_q[head_q];
      free_en        <= has_rd_q[head_q];
      commit_arch_rd <= arch_rd_q[head_q];
      commit_phys_rd <= phys_rd_q[head_q];
      free_phys      <= old_phys_q[head_q];
    end
  end

endmodule
